counter_arbiter: RTL
====================

# counter_arbiter

Shared-counter arbiter and update sequencer. Two requesters each ask to increment or decrement a single bounded counter. The block grants them round-robin, applies one saturating update per grant, and keeps the counter within `[0, MAX_COUNT]` at all times. It sits between request sources and the counter value consumed downstream, so the `counter <= MAX_COUNT` property holds by construction.

## Interface
Parameters:
- `COUNT_W`, 8: counter width. Requires `MAX_COUNT < 2**COUNT_W`.
- `MAX_COUNT`, 100: upper bound of the counter, inclusive.
- `STEP_W`, 4: width of each requester's step value.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear of the counter.
- `req`  in  2  per-requester request; held until granted.
- `dir`  in  2  per-requester direction: 1 = increment, 0 = decrement. Valid while the matching `req` bit is high.
- `step0`  in  STEP_W  update amount for requester 0.
- `step1`  in  STEP_W  update amount for requester 1.
- `gnt`  out  2  one-hot grant, one-cycle pulse.
- `count`  out  COUNT_W  current counter value.
- `sat`  out  1  pulse coincident with `gnt`; the granted update was clamped.
- `busy`  out  1  high while in `GRANT`.

## Operation
- Reset (asynchronous, while `reset_n`=0):
  - `count`=0, `gnt`=0, `sat`=0, `busy`=0.
  - State = `IDLE`; last-granted pointer = 1, so requester 0 wins first.
- FSM states:
  - `IDLE`: evaluate `req` every cycle.
  - `GRANT`: exactly one cycle; always returns to `IDLE`.
- `IDLE` with `clr`=0 and any `req` set:
  - Winner = the requester not granted last if it is requesting, otherwise the only requester.
  - On the same edge: `gnt`<=onehot(winner), `count`<=updated value, `sat`<=clamp flag, pointer<=winner, state<=`GRANT`.
- `IDLE` with no request: no change; `gnt`=0.
- `GRANT`: `gnt`, `sat` and `busy` are high for this cycle. `req` is ignored; the requester must drop `req` at the next edge, or it is treated as a new request.
- Update arithmetic is done in `COUNT_W+1` bits:
  - Increment: `sum = count + step`. If `sum > MAX_COUNT`, then `count=MAX_COUNT` and `sat=1`.
  - Decrement: if `step > count`, then `count=0` and `sat=1`; otherwise `count-step`.
  - `step`=0 is legal: it is granted, `count` is unchanged, `sat`=0.
- `clr`=1:
  - `count`<=0 on that edge, overriding any update.
  - In `IDLE`, no grant is issued that cycle.
  - In `GRANT`, the already-issued grant completes, but its update is discarded.
- Requests change only while `req`=0. Changing `dir` or `step` while requesting is a protocol violation; the values sampled at the grant edge are the ones used.

## Timing
- Request-to-grant latency:
  - `req` rises before edge N in `IDLE` → `gnt` high in cycle N..N+1.
  - The new `count` is visible in the same cycle as `gnt`.
- Throughput: at most one grant every 2 cycles. With both requesters continuously active, grants alternate 0,1,0,1 with `gnt` high every other cycle.
- Worst-case wait for a requester: 4 cycles from `req` to `gnt`.
- Reset asserted mid-`GRANT`: outputs go to reset values immediately; the pending update is lost.
- `sat` is only ever high together with `gnt`.

## Configuration
- `COUNTER_ARB_SVA_EN` defined: embedded concurrent assertions compile in. Each is clocked on `posedge clk`, `disable iff (!reset_n)`, and reports via `$error`. They check:
  - `count <= MAX_COUNT`;
  - `$onehot0(gnt)`;
  - `gnt` never high in two consecutive cycles;
  - `gnt[i]` implies `$past(req[i])`;
  - `sat` implies `|gnt`.
- Not defined: no assertions are compiled; RTL behaviour is identical.

## Test plan
- Reset, then requester 0 increments by 5, ten times → `count` steps 5,10,…,50. Each `gnt` is 1 cycle wide and `sat`=0 throughout.
- `count`=98, increment by 7 → `count`=100, `sat`=1. A further increment by 1 → `count`=100, `sat`=1. Decrement by 3 → `count`=97, `sat`=0.
- `count`=2, decrement by 9 → `count`=0, `sat`=1. Decrement by 0 → granted, `count`=0, `sat`=0.
- Both `req` held with both increments of 1 (after reset, `count`=0) → `gnt` sequence 01,10,01,10 on alternate cycles; `count` rises by 1 per grant.
- `clr` asserted in the same cycle as a pending request in `IDLE` → no grant that cycle, `count`=0, grant issued the next cycle. `clr` asserted during `GRANT` → `gnt` still pulses, `count`=0.
- `reset_n` dropped mid-`GRANT`, build with `COUNTER_ARB_SVA_EN` → `count`, `gnt` and `sat` go to 0 asynchronously and no assertion fires.

Source files
------------

// File: rtl/counter_arbiter_if.sv
// Request/grant bus between two counter requesters and the counter_arbiter.
interface counter_arbiter_if #(
  parameter int COUNT_W = 8,
  parameter int STEP_W  = 4
);
  logic [1:0]         req;
  logic [1:0]         dir;
  logic [STEP_W-1:0]  step0;
  logic [STEP_W-1:0]  step1;
  logic               clr;
  logic [1:0]         gnt;
  logic [COUNT_W-1:0] count;
  logic               sat;
  logic               busy;

  modport master (
    output req, dir, step0, step1, clr,
    input  gnt, count, sat, busy
  );

  modport slave (
    input  req, dir, step0, step1, clr,
    output gnt, count, sat, busy
  );
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin arbiter applying saturating inc/dec updates to a shared counter
// bounded to [0, MAX_COUNT]. Define COUNTER_ARB_SVA_EN to compile in the embedded assertions.
module counter_arbiter #(
  parameter int COUNT_W   = 8,
  parameter int MAX_COUNT = 100,
  parameter int STEP_W    = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  counter_arbiter_if.slave bus
);

  localparam logic [COUNT_W:0]   MAX_X = (COUNT_W+1)'(MAX_COUNT);
  localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_COUNT);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic               ptr;
  logic [1:0]         gnt_q;
  logic [COUNT_W-1:0] count_q;
  logic               sat_q;
  logic               busy_q;

  logic               win;
  logic [STEP_W-1:0]  win_step;
  logic               win_dir;
  logic [COUNT_W:0]   upd;

  // Returns {clamped, next_count}; all arithmetic in COUNT_W+1 bits so the
  // increment overflow is visible before clamping.
  function automatic logic [COUNT_W:0] apply_step(
    input logic [COUNT_W-1:0] cur,
    input logic [STEP_W-1:0]  stp,
    input logic               up
  );
    logic [COUNT_W:0]   cur_x;
    logic [COUNT_W:0]   stp_x;
    logic [COUNT_W:0]   sum;
    logic [COUNT_W-1:0] diff;
    cur_x = {1'b0, cur};
    stp_x = {{(COUNT_W+1-STEP_W){1'b0}}, stp};
    sum   = cur_x + stp_x;
    diff  = cur - {{(COUNT_W-STEP_W){1'b0}}, stp};
    if (up) begin
      if (sum > MAX_X) return {1'b1, MAX_C};
      return {1'b0, sum[COUNT_W-1:0]};
    end
    if (stp_x > cur_x) return {1'b1, {COUNT_W{1'b0}}};
    return {1'b0, diff};
  endfunction

  // Prefer the requester not granted last; fall back to whoever is asking.
  always_comb begin
    win      = bus.req[~ptr] ? ~ptr : ptr;
    win_step = win ? bus.step1 : bus.step0;
    win_dir  = bus.dir[win];
    upd      = apply_step(count_q, win_step, win_dir);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ptr     <= 1'b1;
      gnt_q   <= 2'b00;
      count_q <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr) begin
            count_q <= '0;
            gnt_q   <= 2'b00;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if (|bus.req) begin
            gnt_q   <= win ? 2'b10 : 2'b01;
            count_q <= upd[COUNT_W-1:0];
            sat_q   <= upd[COUNT_W];
            ptr     <= win;
            busy_q  <= 1'b1;
            state   <= GRANT;
          end else begin
            gnt_q   <= 2'b00;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        GRANT: begin
          // The grant pulse always completes; clr only wipes the applied update.
          if (bus.clr) count_q <= '0;
          gnt_q  <= 2'b00;
          sat_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.count = count_q;
  assign bus.sat   = sat_q;
  assign bus.busy  = busy_q;

`ifdef COUNTER_ARB_SVA_EN
  a_count_max: assert property (@(posedge clk) disable iff (!reset_n)
    count_q <= MAX_C) else $error("count above MAX_COUNT");
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(gnt_q)) else $error("gnt not one-hot");
  a_gnt_gap: assert property (@(posedge clk) disable iff (!reset_n)
    |gnt_q |=> !(|gnt_q)) else $error("gnt high two cycles in a row");
  a_gnt0_req: assert property (@(posedge clk) disable iff (!reset_n)
    gnt_q[0] |-> $past(bus.req[0])) else $error("gnt[0] without req[0]");
  a_gnt1_req: assert property (@(posedge clk) disable iff (!reset_n)
    gnt_q[1] |-> $past(bus.req[1])) else $error("gnt[1] without req[1]");
  a_sat_gnt: assert property (@(posedge clk) disable iff (!reset_n)
    sat_q |-> |gnt_q) else $error("sat without gnt");
`else
  // Assertions excluded from this build.
`endif

endmodule
